fdivsqrt_iter_sched: RTL

- Sequencing controller for the shared divide/square-root unit.
- Accepts one operation at a time from the execute stage and latches the operation's result exponent from the exponent-calculation datapath.
- Counts the digit-recurrence iterations the selected format needs, drives iteration enables, and holds completion until the memory stage accepts it.
- Handles special-case early termination, flush and stall.

---
 rtl/fdivsqrt_iter_sched_pkg.sv | 30 +++
 rtl/fdivsqrt_iter_sched_if.sv | 33 +++
 rtl/fdivsqrt_cyclecalc.sv | 32 +++
 rtl/fdivsqrt_iter_sched.sv | 75 +++++++
 4 files changed

// File: rtl/fdivsqrt_iter_sched_pkg.sv
// Shared types and constants for the divide/sqrt iteration scheduler.
package fdivsqrt_iter_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Fmt encoding
   localparam logic [1:0] FMT_S = 2'b00;
   localparam logic [1:0] FMT_D = 2'b01;
   localparam logic [1:0] FMT_H = 2'b10;
   localparam logic [1:0] FMT_Q = 2'b11;

   // Fraction width per format
   localparam int NF_S = 23;
   localparam int NF_D = 52;
   localparam int NF_H = 10;
   localparam int NF_Q = 112;

   // Counter width, large enough for the quad count of 30
   localparam int DURLEN = 5;

   // ceil((nf+3+sqrt)/rk)+1 : recurrence cycles including the final step
   function automatic int iter_cycles(input int nf, input logic sqrt, input int rk);
      return (nf + 3 + int'(sqrt) + rk - 1) / rk + 1;
   endfunction

endpackage

// File: rtl/fdivsqrt_iter_sched_if.sv
// Handshake bundle between execute/memory stages and the iteration scheduler.
interface fdivsqrt_iter_sched_if #(
   parameter int NE     = 15,
   parameter int DURLEN = 5
);
   logic              Start;
   logic              Ready;
   logic [1:0]        Fmt;
   logic              Sqrt;
   logic              SpecialCase;
   logic [NE+1:0]     UeIn;
   logic              FlushE;
   logic              StallM;
   logic              InitIter;
   logic              IterEn;
   logic              Busy;
   logic              Done;
   logic [NE+1:0]     UeOut;
   logic              SpecialOut;
   logic [DURLEN-1:0] Cnt;

   // pipeline side: issues ops, flushes, stalls
   modport master (
      output Start, Fmt, Sqrt, SpecialCase, UeIn, FlushE, StallM,
      input  Ready, InitIter, IterEn, Busy, Done, UeOut, SpecialOut, Cnt
   );

   // scheduler side
   modport slave (
      input  Start, Fmt, Sqrt, SpecialCase, UeIn, FlushE, StallM,
      output Ready, InitIter, IterEn, Busy, Done, UeOut, SpecialOut, Cnt
   );
endinterface

// File: rtl/fdivsqrt_cyclecalc.sv
// Fmt/Sqrt -> iteration count lookup, constants folded at elaboration.
module fdivsqrt_cyclecalc #(
   parameter int RK     = 4,
   parameter int DURLEN = fdivsqrt_iter_sched_pkg::DURLEN
) (
   input  logic [1:0]        Fmt,
   input  logic              Sqrt,
   output logic [DURLEN-1:0] N
);
   import fdivsqrt_iter_sched_pkg::*;

   localparam logic [DURLEN-1:0] N_S_DIV = DURLEN'(iter_cycles(NF_S, 1'b0, RK));
   localparam logic [DURLEN-1:0] N_S_SQ  = DURLEN'(iter_cycles(NF_S, 1'b1, RK));
   localparam logic [DURLEN-1:0] N_D_DIV = DURLEN'(iter_cycles(NF_D, 1'b0, RK));
   localparam logic [DURLEN-1:0] N_D_SQ  = DURLEN'(iter_cycles(NF_D, 1'b1, RK));
   localparam logic [DURLEN-1:0] N_H_DIV = DURLEN'(iter_cycles(NF_H, 1'b0, RK));
   localparam logic [DURLEN-1:0] N_H_SQ  = DURLEN'(iter_cycles(NF_H, 1'b1, RK));
   localparam logic [DURLEN-1:0] N_Q_DIV = DURLEN'(iter_cycles(NF_Q, 1'b0, RK));
   localparam logic [DURLEN-1:0] N_Q_SQ  = DURLEN'(iter_cycles(NF_Q, 1'b1, RK));

   // select the per-format count
   always_comb begin
      N = '0;
      case (Fmt)
         FMT_S:   N = Sqrt ? N_S_SQ : N_S_DIV;
         FMT_D:   N = Sqrt ? N_D_SQ : N_D_DIV;
         FMT_H:   N = Sqrt ? N_H_SQ : N_H_DIV;
         FMT_Q:   N = Sqrt ? N_Q_SQ : N_Q_DIV;
         default: N = '0;
      endcase
   end
endmodule

// File: rtl/fdivsqrt_iter_sched.sv
// Sequencer for the shared divide/sqrt unit: accept, iterate N cycles,
// hold the result until the memory stage takes it.
module fdivsqrt_iter_sched #(
   parameter int NE     = 15,
   parameter int RK     = 4,
   parameter int DURLEN = fdivsqrt_iter_sched_pkg::DURLEN
) (
   input logic                  clk,
   input logic                  reset,
   fdivsqrt_iter_sched_if.slave bus
);
   import fdivsqrt_iter_sched_pkg::*;

   state_t            state;
   logic [DURLEN-1:0] cnt;
   logic [DURLEN-1:0] n_cyc;
   logic [NE+1:0]     ue_q;
   logic              spec_q;
   logic              ready;
   logic              accept;

   fdivsqrt_cyclecalc #(.RK(RK), .DURLEN(DURLEN)) u_cyclecalc (
      .Fmt  (bus.Fmt),
      .Sqrt (bus.Sqrt),
      .N    (n_cyc)
   );

   // a held result frees the unit only in the cycle it is consumed
   assign ready  = (state == IDLE) | ((state == DONE) & ~bus.StallM);
   assign accept = bus.Start & ready & ~bus.FlushE;

   // FSM, iteration counter and capture registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         ue_q   <= '0;
         spec_q <= 1'b0;
      end else if (bus.FlushE) begin
         // flush beats any same-cycle start; exponent is left as-is
         state <= IDLE;
         cnt   <= '0;
      end else if (accept) begin
         ue_q   <= bus.UeIn;
         spec_q <= bus.SpecialCase;
         if (bus.SpecialCase) begin
            state <= DONE;
            cnt   <= '0;
         end else begin
            state <= BUSY;
            cnt   <= n_cyc - DURLEN'(1);
         end
      end else begin
         case (state)
            BUSY: begin
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - DURLEN'(1);
            end
            DONE: begin
               if (!bus.StallM) state <= IDLE;
            end
            default: ;
         endcase
      end
   end

   assign bus.Ready      = ready;
   assign bus.InitIter   = accept;
   assign bus.IterEn     = (state == BUSY);
   assign bus.Busy       = (state == BUSY);
   assign bus.Done       = (state == DONE);
   assign bus.UeOut      = ue_q;
   assign bus.SpecialOut = spec_q;
   assign bus.Cnt        = cnt;
endmodule
